// File: rtl/byte_packer_8_32_if.sv
// Byte-in / word-out handshake bundle for byte_packer_8_32.
// master drives bytes and out_ready; slave returns the FIFO head.
interface byte_packer_8_32_if #(
    parameter int PTR_W = 2
);
    logic             in;
    logic [7:0]       in_data;
    logic             out_ready;
    logic             out;
    logic [31:0]      out_data;
    logic             overflow;
    logic [PTR_W:0]   count;

    modport master (
        output in, in_data, out_ready,
        input  out, out_data, overflow, count
    );

    modport slave (
        input  in, in_data, out_ready,
        output out, out_data, overflow, count
    );
endinterface

// File: rtl/byte_packer_8_32.sv
// Packs an MSB-first byte stream into 32-bit words and queues them in a word FIFO.
// Optional macro PACK_PARTIAL_FLUSH_EN: an aborted partial word is pushed zero-filled.
module byte_packer_8_32 #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk_4f,
    input  logic                reset_L,
    byte_packer_8_32_if.slave   bus
);

    logic [1:0]        byte_idx;
    logic [23:0]       lanes;
    logic [31:0]       mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    cnt;
    logic              ovf;

    logic              empty;
    logic              full;
    logic              pop;
    logic              push;
    logic              push_ok;
    logic [31:0]       push_word;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(DEPTH));
    assign pop     = !empty && bus.out_ready;
    // A pop on the same edge frees the slot the push needs.
    assign push_ok = push && (!full || pop);

    always_comb begin
        push      = 1'b0;
        push_word = 32'h0;
        if (bus.in && byte_idx == 2'd3) begin
            push      = 1'b1;
            push_word = {lanes, bus.in_data};
        end
`ifdef PACK_PARTIAL_FLUSH_EN
        else if (!bus.in && byte_idx != 2'd0) begin
            push = 1'b1;
            // Lanes at or past byte_idx may hold stale bytes; mask them.
            case (byte_idx)
                2'd1:    push_word = {lanes[23:16], 24'h0};
                2'd2:    push_word = {lanes[23:8], 16'h0};
                default: push_word = {lanes, 8'h0};
            endcase
        end
`endif
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            byte_idx <= 2'd0;
            lanes    <= 24'h0;
        end else if (bus.in) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    lanes[23:16] <= bus.in_data;
                2'd1:    lanes[15:8]  <= bus.in_data;
                2'd2:    lanes[7:0]   <= bus.in_data;
                default: lanes        <= lanes;
            endcase
        end else begin
            byte_idx <= 2'd0;
        end
    end

    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                ovf <= 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.out      = !empty;
    assign bus.out_data = empty ? 32'h0 : mem[rd_ptr];
    assign bus.overflow = ovf;
    assign bus.count    = cnt;

endmodule
